// File: rtl/sap_pkg.sv
// Shared definitions for the SAP memory slice.
//   SAP_ADDR_W / SAP_DATA_W : default MAR/RAM address width and bus/word width
//   prog_state_t            : program-load FSM states (IDLE, LOAD, DONE)
//   sap_last_addr()         : highest RAM address for a given address width
package sap_pkg;

  localparam int SAP_ADDR_W = 4;
  localparam int SAP_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } prog_state_t;

  function automatic int sap_last_addr(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage

// File: rtl/sap_ram16x8.sv
// Flop-based RAM for the SAP memory unit.
//   clk, rst_n : clock; asynchronous active-low clear of every word
//   we         : synchronous write enable
//   waddr      : write address
//   wdata      : write data
//   raddr      : combinational read address
//   rdata      : read data (reflects contents before a same-cycle write)
module sap_ram16x8 #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Reset clears the whole array so an aborted program load leaves no stale bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sap_memory_unit.sv
// SAP memory unit: MAR + 16x8 RAM on the CPU bus, plus the byte-wide
// program-load port that fills RAM before the CPU runs.
//   clk, rst_n  : system clock; asynchronous active-low reset
//   bus_in      : bus value (address in low ADDR_W bits, or write data)
//   bus_out     : RAM read data toward the bus (zero when not driving)
//   bus_oe      : bus_out is driving this cycle
//   lm, ce, we  : run-mode controls: load MAR, drive mem[MAR], write mem[MAR]
//   prog_mode   : 1 = program-load mode, run controls ignored
//   prog_valid  : load-port byte offered
//   prog_data   : load-port byte
//   prog_ready  : load port can accept a byte
//   prog_done   : every RAM word has been loaded
//   mar_out     : current MAR value
module sap_memory_unit
  import sap_pkg::*;
#(
  parameter int ADDR_W = SAP_ADDR_W,
  parameter int DATA_W = SAP_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic              lm,
  input  logic              ce,
  input  logic              we,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic [ADDR_W-1:0] mar_out
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(sap_last_addr(ADDR_W));

  prog_state_t       state_q;
  prog_state_t       state_d;
  logic [ADDR_W-1:0] mar_q;
  logic [ADDR_W-1:0] wr_ptr_q;

  logic              run_en;
  logic              load_accept;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Run controls only act with the load FSM parked in IDLE, so the cycle
  // that leaves DONE/LOAD after prog_mode drops is still guarded.
  assign run_en      = !prog_mode && (state_q == IDLE);
  assign load_accept = prog_ready && prog_valid;

  // Program-load FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Program-load FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (prog_mode) state_d = LOAD;
      end
      LOAD: begin
        if (!prog_mode) begin
          state_d = IDLE;
        end else if (load_accept && (wr_ptr_q == LAST_ADDR)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!prog_mode) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Program-load FSM: outputs. prog_done comes straight from the registered
  // state, so it rises the cycle after the last byte is accepted.
  always_comb begin
    prog_ready = 1'b0;
    prog_done  = 1'b0;
    case (state_q)
      LOAD:    prog_ready = prog_mode;
      DONE:    prog_done  = 1'b1;
      default: ;
    endcase
  end

  // Load pointer: cleared whenever program mode is off; after the last word
  // it wraps to 0 but the FSM is in DONE so no further writes happen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
    end else if (!prog_mode) begin
      wr_ptr_q <= '0;
    end else if (load_accept) begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
    end
  end

  // MAR: a same-cycle we still sees the old MAR through the write-port mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar_q <= '0;
    end else if (run_en && lm) begin
      mar_q <= bus_in[ADDR_W-1:0];
    end
  end

  // Write-port mux: load path and run path are mutually exclusive because
  // load_accept needs prog_mode=1 and run_en needs prog_mode=0.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = mar_q;
    ram_wdata = bus_in;
    if (load_accept) begin
      ram_we    = 1'b1;
      ram_waddr = wr_ptr_q;
      ram_wdata = prog_data;
    end else if (run_en && we) begin
      ram_we    = 1'b1;
    end
  end

  sap_ram16x8 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (mar_q),
    .rdata (ram_rdata)
  );

  // The bus driver is released as soon as reset asserts, without waiting on a clock.
  assign bus_oe  = rst_n && run_en && ce;
  assign bus_out = bus_oe ? ram_rdata : '0;
  assign mar_out = mar_q;

endmodule

// File: tb/tb_sap_memory_unit.sv
module tb_sap_memory_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       lm;
  logic       ce;
  logic       we;
  logic       prog_mode;
  logic       prog_valid;
  logic [7:0] prog_data;
  logic       prog_ready;
  logic       prog_done;
  logic [3:0] mar_out;

  int total = 0;
  int bad   = 0;

  // Reference model: plain memory image and MAR value.
  logic [7:0] ref_mem [16];
  logic [3:0] ref_mar;

  sap_memory_unit #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .lm         (lm),
    .ce         (ce),
    .we         (we),
    .prog_mode  (prog_mode),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_ready (prog_ready),
    .prog_done  (prog_done),
    .mar_out    (mar_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load MAR with addr (random upper bits on the bus), then drive ce and sample.
  task automatic read_word(input logic [3:0] addr, output logic [7:0] data, output logic oe);
    logic [3:0] junk;
    junk   = 4'($urandom);
    bus_in = {junk, addr};
    lm     = 1'b1;
    step();
    lm      = 1'b0;
    ref_mar = addr;
    ce      = 1'b1;
    #1;
    data = bus_out;
    oe   = bus_oe;
    ce   = 1'b0;
    step();
  endtask

  task automatic test_reset();
    lm     = 1'b1;
    bus_in = 8'hA7;
    step();
    lm      = 1'b0;
    ref_mar = 4'h7;
    total++;
    if (mar_out !== 4'h7) begin
      bad++;
      $display("FAIL reset_pre_mar: got %h expected %h", mar_out, 4'h7);
    end
    prog_mode = 1'b1;
    step();
    total++;
    if (prog_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_ready: got %b expected 1", prog_ready);
    end
    prog_mode = 1'b0;
    ce        = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    ref_mar = 4'h0;
    total++;
    if (mar_out !== 4'h0 || bus_oe !== 1'b0 || prog_ready !== 1'b0 || prog_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: mar=%h oe=%b ready=%b done=%b expected 0 0 0 0",
               mar_out, bus_oe, prog_ready, prog_done);
    end
    total++;
    if (bus_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_bus_out: got %h expected 00", bus_out);
    end
    ce = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load();
    logic [7:0] d;
    logic       oe;
    prog_mode  = 1'b1;
    prog_valid = 1'b0;
    step();
    total++;
    if (prog_ready !== 1'b1) begin
      bad++;
      $display("FAIL load_ready: got %b expected 1", prog_ready);
    end
    for (int i = 0; i < 16; i++) begin
      prog_data  = 8'h10 + 8'(i);
      prog_valid = 1'b1;
      ref_mem[i] = 8'h10 + 8'(i);
      if (i == 15) begin
        total++;
        if (prog_done !== 1'b0) begin
          bad++;
          $display("FAIL load_done_early: got %b expected 0", prog_done);
        end
      end
      step();
    end
    total++;
    if (prog_done !== 1'b1 || prog_ready !== 1'b0) begin
      bad++;
      $display("FAIL load_done: done=%b ready=%b expected 1 0", prog_done, prog_ready);
    end
    prog_data = 8'hAA;
    step();
    prog_valid = 1'b0;
    prog_mode  = 1'b0;
    step();
    read_word(4'h5, d, oe);
    total++;
    if (d !== 8'h15 || oe !== 1'b1) begin
      bad++;
      $display("FAIL load_read5: data=%h oe=%b expected 15 1", d, oe);
    end
    read_word(4'h0, d, oe);
    total++;
    if (d !== 8'h10) begin
      bad++;
      $display("FAIL load_no_wrap: mem[0]=%h expected 10", d);
    end
    total++;
    if (mar_out !== ref_mar) begin
      bad++;
      $display("FAIL load_mar: got %h expected %h", mar_out, ref_mar);
    end
  endtask

  task automatic test_backpressure();
    int         acc;
    logic [7:0] d;
    logic       oe;
    acc        = 0;
    prog_mode  = 1'b1;
    prog_valid = 1'b0;
    step();
    for (int cyc = 0; cyc < 300 && acc < 16; cyc++) begin
      prog_valid = 1'($urandom);
      prog_data  = 8'($urandom);
      #1;
      total++;
      if (prog_ready !== 1'b1) begin
        bad++;
        $display("FAIL bp_ready: cycle %0d got %b expected 1", cyc, prog_ready);
      end
      if (prog_valid) begin
        ref_mem[acc] = prog_data;
        acc++;
      end
      step();
    end
    prog_valid = 1'b0;
    total++;
    if (acc != 16) begin
      bad++;
      $display("FAIL bp_timeout: accepted %0d expected 16", acc);
    end
    total++;
    if (prog_done !== 1'b1) begin
      bad++;
      $display("FAIL bp_done: got %b expected 1", prog_done);
    end
    prog_mode = 1'b0;
    step();
    for (int a = 0; a < 16; a++) begin
      read_word(4'(a), d, oe);
      total++;
      if (d !== ref_mem[a]) begin
        bad++;
        $display("FAIL bp_ram: mem[%0d]=%h expected %h", a, d, ref_mem[a]);
      end
    end
  endtask

  task automatic test_lm_we();
    logic [7:0] d;
    logic       oe;
    bus_in = 8'h03;
    lm     = 1'b1;
    step();
    ref_mar = 4'h3;
    bus_in  = 8'h09;
    we      = 1'b1;
    step();
    ref_mem[ref_mar] = 8'h09;
    ref_mar          = 4'h9;
    lm = 1'b0;
    we = 1'b0;
    total++;
    if (mar_out !== ref_mar) begin
      bad++;
      $display("FAIL lmwe_mar: got %h expected %h", mar_out, ref_mar);
    end
    // ce+we in one cycle: old data before the edge, new data after.
    ce     = 1'b1;
    we     = 1'b1;
    bus_in = 8'h5C;
    #1;
    total++;
    if (bus_out !== ref_mem[9]) begin
      bad++;
      $display("FAIL cewe_old: got %h expected %h", bus_out, ref_mem[9]);
    end
    step();
    ref_mem[9] = 8'h5C;
    we = 1'b0;
    #1;
    total++;
    if (bus_out !== 8'h5C || bus_oe !== 1'b1) begin
      bad++;
      $display("FAIL cewe_new: data=%h oe=%b expected 5c 1", bus_out, bus_oe);
    end
    ce = 1'b0;
    step();
    read_word(4'h3, d, oe);
    total++;
    if (d !== 8'h09) begin
      bad++;
      $display("FAIL lmwe_mem3: got %h expected 09", d);
    end
    // Leave MAR at 9 for the mode-guard scenario.
    read_word(4'h9, d, oe);
    total++;
    if (d !== ref_mem[9]) begin
      bad++;
      $display("FAIL lmwe_mem9: got %h expected %h", d, ref_mem[9]);
    end
  endtask

  task automatic test_mode_guard();
    logic [7:0] d;
    logic       oe;
    logic [3:0] held;
    held       = ref_mar;
    prog_mode  = 1'b1;
    prog_valid = 1'b0;
    lm = 1'b1;
    ce = 1'b1;
    we = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus_in = 8'($urandom);
      #1;
      total++;
      if (bus_oe !== 1'b0 || bus_out !== 8'h00) begin
        bad++;
        $display("FAIL guard_bus: oe=%b data=%h expected 0 00", bus_oe, bus_out);
      end
      step();
    end
    lm = 1'b0;
    ce = 1'b0;
    we = 1'b0;
    prog_mode = 1'b0;
    step();
    total++;
    if (mar_out !== held) begin
      bad++;
      $display("FAIL guard_mar: got %h expected %h", mar_out, held);
    end
    for (int a = 0; a < 16; a++) begin
      read_word(4'(a), d, oe);
      total++;
      if (d !== ref_mem[a]) begin
        bad++;
        $display("FAIL guard_ram: mem[%0d]=%h expected %h", a, d, ref_mem[a]);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    logic       oe;
    prog_mode = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      prog_valid = 1'b1;
      prog_data  = 8'($urandom) | 8'h01;
      step();
    end
    prog_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    for (int a = 0; a < 16; a++) ref_mem[a] = 8'h00;
    ref_mar = 4'h0;
    #1;
    total++;
    if (prog_ready !== 1'b0 || mar_out !== 4'h0) begin
      bad++;
      $display("FAIL abort_reset: ready=%b mar=%h expected 0 0", prog_ready, mar_out);
    end
    prog_mode = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int a = 0; a < 16; a++) begin
      read_word(4'(a), d, oe);
      total++;
      if (d !== 8'h00) begin
        bad++;
        $display("FAIL abort_cleared: mem[%0d]=%h expected 00", a, d);
      end
    end
    // Reload from scratch: first byte must land at address 0.
    prog_mode = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      prog_valid = 1'b1;
      prog_data  = 8'($urandom);
      ref_mem[i] = prog_data;
      step();
    end
    prog_valid = 1'b0;
    total++;
    if (prog_done !== 1'b1) begin
      bad++;
      $display("FAIL reload_done: got %b expected 1", prog_done);
    end
    prog_mode = 1'b0;
    step();
    for (int a = 0; a < 16; a++) begin
      read_word(4'(a), d, oe);
      total++;
      if (d !== ref_mem[a]) begin
        bad++;
        $display("FAIL reload_ram: mem[%0d]=%h expected %h", a, d, ref_mem[a]);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    bus_in     = 8'h00;
    lm         = 1'b0;
    ce         = 1'b0;
    we         = 1'b0;
    prog_mode  = 1'b0;
    prog_valid = 1'b0;
    prog_data  = 8'h00;
    ref_mar    = 4'h0;
    for (int a = 0; a < 16; a++) ref_mem[a] = 8'h00;
    step();
    step();
    rst_n = 1'b1;
    step();

    test_reset();
    test_load();
    test_backpressure();
    test_lm_we();
    test_mode_guard();
    test_abort();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
